cosim_trace_tx: RTL and testbench

- Core-side transmitter for the co-simulation commit trace. Captures per-cycle ROB commit bundles (up to COMMIT_WIDTH lanes) plus the interrupt/exception trap event.
- Compacts them in architectural order into a FIFO and emits one trace beat per handshake toward the cosim bridge / DPI stepper.
- Decouples core commit timing from the checker and guarantees ordering: all commits of a cycle precede that cycle's trap.

---
 rtl/cosim_trace_pkg.sv | 23 ++
 rtl/cosim_trace_fifo.sv | 55 +++++
 rtl/cosim_trace_tx.sv | 132 +++++++++++++
 tb/tb_cosim_trace_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_trace_pkg.sv
// rtl/cosim_trace_pkg.sv - shared types for the cosim commit-trace transmitter
package cosim_trace_pkg;

  localparam int INST_LEN   = 32;
  localparam int HARTID_LEN = 32;
  localparam int TRACE_XLEN = 64;

  typedef enum logic {
    COMMIT = 1'b0,
    TRAP   = 1'b1
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e           kind;
    logic [TRACE_XLEN-1:0] pc;
    logic [INST_LEN-1:0]   inst;
    logic [TRACE_XLEN-1:0] wdata;
    logic [TRACE_XLEN-1:0] mstatus;
    logic                  check;
    logic [TRACE_XLEN-1:0] cause;
  } trace_entry_t;

endpackage

// File: rtl/cosim_trace_fifo.sv
// rtl/cosim_trace_fifo.sv - multi-write, single-read circular buffer of trace entries
module cosim_trace_fifo
  import cosim_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NWR   = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       wr_cnt_i,
  input  trace_entry_t [NWR-1:0] wr_data_i,
  input  logic                   pop_i,
  output trace_entry_t           head_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits, so truncating the add wraps them.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + wr_cnt_i - CNT_W'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NWR; i++) begin
      if (CNT_W'(i) < wr_cnt_i) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= wr_data_i[i];
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cosim_trace_tx.sv
// rtl/cosim_trace_tx.sv - compacts per-cycle commit lanes and trap into an ordered trace stream
module cosim_trace_tx
  import cosim_trace_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 8,
  parameter int SEQ_W        = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [HARTID_LEN-1:0]        hartid,
  output logic [HARTID_LEN-1:0]        out_hartid,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_trap,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_kind,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [INST_LEN-1:0]          out_inst,
  output logic                         out_check,
  output logic [XLEN-1:0]              out_cause,
  output logic [SEQ_W-1:0]             out_seq,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow
);

  localparam int NWR   = COMMIT_WIDTH + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - NWR);

  trace_entry_t [COMMIT_WIDTH-1:0] lane_e;
  logic [CNT_W-1:0]                lane_pos [COMMIT_WIDTH];
  logic [CNT_W-1:0]                n_commit;
  logic [CNT_W-1:0]                pushes;
  logic [CNT_W-1:0]                wr_cnt;
  logic [CNT_W-1:0]                count;
  trace_entry_t [NWR-1:0]          slot;
  trace_entry_t                    head;
  logic                            pop;
  logic [SEQ_W-1:0]                seq_q, seq_d;
  logic                            overflow_q, overflow_d;

  // Prefix popcount gives each valid lane its slot in the compacted bundle.
  always_comb begin
    n_commit = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_pos[i] = n_commit;
      n_commit    = n_commit + CNT_W'(in_valid[i]);
      lane_e[i]   = '{kind:    COMMIT,
                      pc:      TRACE_XLEN'(in_pc[i*XLEN +: XLEN]),
                      inst:    in_inst[i*INST_LEN +: INST_LEN],
                      wdata:   TRACE_XLEN'(in_wdata[i*XLEN +: XLEN]),
                      mstatus: TRACE_XLEN'(in_mstatus[i*XLEN +: XLEN]),
                      check:   in_check[i],
                      cause:   '0};
    end
    pushes = n_commit + CNT_W'(in_trap);
  end

  // The trap always lands right after the last valid commit of the cycle.
  always_comb begin
    slot = '0;
    for (int j = 0; j < NWR; j++) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i] && lane_pos[i] == CNT_W'(j)) begin
          slot[j] = lane_e[i];
        end
      end
      if (in_trap && n_commit == CNT_W'(j)) begin
        slot[j] = '{kind: TRAP, pc: '0, inst: '0, wdata: '0, mstatus: '0,
                    check: 1'b0, cause: TRACE_XLEN'(in_cause)};
      end
    end
  end

  assign in_ready  = (count <= READY_MAX);
  assign wr_cnt    = in_ready ? pushes : '0;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  cosim_trace_fifo #(
    .DEPTH (DEPTH),
    .NWR   (NWR),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_cnt_i  (wr_cnt),
    .wr_data_i (slot),
    .pop_i     (pop),
    .head_o    (head),
    .count_o   (count)
  );

  always_comb begin
    seq_d      = pop ? seq_q + SEQ_W'(1) : seq_q;
    overflow_d = overflow_q || (!in_ready && pushes != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_hartid  = hartid;
  assign out_kind    = out_valid && (head.kind == TRAP);
  assign out_pc      = out_valid ? head.pc[XLEN-1:0] : '0;
  assign out_wdata   = out_valid ? head.wdata[XLEN-1:0] : '0;
  assign out_mstatus = out_valid ? head.mstatus[XLEN-1:0] : '0;
  assign out_inst    = out_valid ? head.inst : '0;
  assign out_check   = out_valid && head.check;
  assign out_cause   = out_valid ? head.cause[XLEN-1:0] : '0;
  assign out_seq     = seq_q;
  assign occupancy   = count;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cosim_trace_tx.sv
// tb/tb_cosim_trace_tx.sv - scoreboard bench for the cosim trace transmitter
module tb_cosim_trace_tx;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  hartid = 32'h5;
  logic [31:0]  out_hartid;
  logic [1:0]   in_valid = '0;
  logic [127:0] in_pc = '0;
  logic [63:0]  in_inst = '0;
  logic [127:0] in_wdata = '0;
  logic [127:0] in_mstatus = '0;
  logic [1:0]   in_check = '0;
  logic         in_trap = 1'b0;
  logic [63:0]  in_cause = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_kind;
  logic [63:0]  out_pc, out_wdata, out_mstatus, out_cause;
  logic [31:0]  out_inst;
  logic         out_check;
  logic [15:0]  out_seq;
  logic [3:0]   occupancy;
  logic         overflow;

  cosim_trace_tx dut (
    .clock(clock), .reset(reset), .hartid(hartid), .out_hartid(out_hartid),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
    .in_mstatus(in_mstatus), .in_check(in_check), .in_trap(in_trap),
    .in_cause(in_cause), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc),
    .out_wdata(out_wdata), .out_mstatus(out_mstatus), .out_inst(out_inst),
    .out_check(out_check), .out_cause(out_cause), .out_seq(out_seq),
    .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic        check;
    logic [63:0] cause;
    logic [15:0] seq;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] push_seq = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_inst(input logic [63:0] pc);
    return 32'h13 | {pc[27:0], 4'h0};
  endfunction
  function automatic logic [63:0] f_mst(input logic [63:0] pc);
    return {32'h0, pc[31:0]} ^ 64'hA00;
  endfunction

  task automatic push_commit(input logic [63:0] pc);
    exp_t e;
    e = '{kind: 1'b0, pc: pc, inst: f_inst(pc), wdata: ~pc, mstatus: f_mst(pc),
          check: ~pc[2], cause: 64'h0, seq: push_seq};
    exp_q.push_back(e);
    push_seq++;
  endtask

  task automatic set_bundle(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                            input logic trap, input logic [63:0] cause, input bit accept);
    exp_t e;
    in_valid   = v;
    in_pc      = {pc1, pc0};
    in_inst    = {f_inst(pc1), f_inst(pc0)};
    in_wdata   = {~pc1, ~pc0};
    in_mstatus = {f_mst(pc1), f_mst(pc0)};
    in_check   = {~pc1[2], ~pc0[2]};
    in_trap    = trap;
    in_cause   = cause;
    if (accept) begin
      if (v[0]) push_commit(pc0);
      if (v[1]) push_commit(pc1);
      if (trap) begin
        e = '{kind: 1'b1, pc: 64'h0, inst: 32'h0, wdata: 64'h0, mstatus: 64'h0,
              check: 1'b0, cause: cause, seq: push_seq};
        exp_q.push_back(e);
        push_seq++;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    in_valid = '0;
    in_trap  = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) step();
    chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'h0);
  endtask

  // Monitor: compares every accepted head beat against the scoreboard.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", out_pc, 64'h0);
        end else begin
          e = exp_q.pop_front();
          ok = out_kind == e.kind && out_pc == e.pc && out_inst == e.inst &&
               out_wdata == e.wdata && out_mstatus == e.mstatus &&
               out_check == e.check && out_cause == e.cause && out_seq == e.seq;
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL beat seq act=%h exp=%h kind act=%0d exp=%0d pc act=%h exp=%h inst act=%h exp=%h wdata act=%h exp=%h mst act=%h exp=%h chk act=%0d exp=%0d cause act=%h exp=%h",
                     out_seq, e.seq, out_kind, e.kind, out_pc, e.pc, out_inst, e.inst,
                     out_wdata, e.wdata, out_mstatus, e.mstatus, out_check, e.check,
                     out_cause, e.cause);
          end
        end
      end else if (!out_valid) begin
        chk((out_pc | out_wdata | out_mstatus | out_cause | {32'h0, out_inst}) == 64'h0 &&
            !out_kind && !out_check, "empty_fields_zero", out_pc | out_cause, 64'h0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'h0);
    chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'h1);
    chk(occupancy == 4'd0, "rst_occupancy", 64'(occupancy), 64'h0);
    chk(overflow == 1'b0, "rst_overflow", 64'(overflow), 64'h0);
    chk(out_seq == 16'd0, "rst_seq", 64'(out_seq), 64'h0);
    chk(out_hartid == 32'h5, "hartid_pass", 64'(out_hartid), 64'h5);

    // single commit, first beat visible one cycle after acceptance
    out_ready = 1'b1;
    set_bundle(2'b01, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 1'b1);
    @(negedge clock);
    chk(out_valid == 1'b0, "no_bypass", 64'(out_valid), 64'h0);
    step();
    chk(out_valid == 1'b1, "latency_valid", 64'(out_valid), 64'h1);
    chk(occupancy == 4'd1, "single_occ", 64'(occupancy), 64'h1);
    step();
    chk(occupancy == 4'd0, "single_drained", 64'(occupancy), 64'h0);

    // full bundle plus trap
    set_bundle(2'b11, 64'h100, 64'h104, 1'b1, 64'h8000_0000_0000_0007, 1'b1);
    step();
    chk(occupancy == 4'd3, "bundle_trap_occ", 64'(occupancy), 64'h3);
    wait_drain(10);

    // sparse: lane1 only
    out_ready = 1'b0;
    set_bundle(2'b10, 64'h0, 64'h204, 1'b0, 64'h0, 1'b1);
    step();
    chk(occupancy == 4'd1, "sparse_occ", 64'(occupancy), 64'h1);
    out_ready = 1'b1;
    wait_drain(10);

    // trap alone
    set_bundle(2'b00, 64'h0, 64'h0, 1'b1, 64'hB, 1'b1);
    step();
    wait_drain(10);

    // backpressure: in_ready drops once count reaches 6
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(in_ready == 1'b1, "bp_ready_high", 64'(in_ready), 64'h1);
      chk(occupancy == 4'(2 * k), "bp_occ", 64'(occupancy), 64'(2 * k));
      set_bundle(2'b11, 64'h300 + 64'(16 * k), 64'h308 + 64'(16 * k), 1'b0, 64'h0, 1'b1);
      step();
    end
    chk(in_ready == 1'b0, "bp_ready_low", 64'(in_ready), 64'h0);
    chk(occupancy == 4'd6, "bp_occ_full", 64'(occupancy), 64'h6);
    chk(overflow == 1'b0, "bp_no_overflow", 64'(overflow), 64'h0);

    // violation: push while not ready
    set_bundle(2'b11, 64'h400, 64'h404, 1'b1, 64'h2, 1'b0);
    step();
    chk(occupancy == 4'd6, "viol_occ", 64'(occupancy), 64'h6);
    chk(overflow == 1'b1, "viol_overflow", 64'(overflow), 64'h1);

    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk(out_valid == 1'b1, "drain_no_gap", 64'(out_valid), 64'h1);
      step();
    end
    chk(occupancy == 4'd0, "drain_occ", 64'(occupancy), 64'h0);
    chk(exp_q.size() == 0, "drain_all", 64'(exp_q.size()), 64'h0);
    chk(overflow == 1'b1, "overflow_sticky", 64'(overflow), 64'h1);

    // long stream wraps out_seq and the pointers
    for (int k = 0; k < 70000; k++) begin
      set_bundle(2'b01, 64'h1_0000 + 64'(4 * k), 64'h0, 1'b0, 64'h0, 1'b1);
      step();
    end
    wait_drain(10);
    chk(out_seq == push_seq, "wrap_seq", 64'(out_seq), 64'(push_seq));
    chk(overflow == 1'b1, "overflow_still", 64'(overflow), 64'h1);

    // reset with 5 beats buffered
    out_ready = 1'b0;
    set_bundle(2'b11, 64'h500, 64'h504, 1'b1, 64'h3, 1'b1);
    step();
    set_bundle(2'b11, 64'h510, 64'h514, 1'b0, 64'h0, 1'b1);
    step();
    chk(occupancy == 4'd5, "pre_reset_occ", 64'(occupancy), 64'h5);
    reset = 1'b0;
    exp_q.delete();
    push_seq = '0;
    step();
    reset = 1'b1;
    chk(out_valid == 1'b0, "mid_rst_valid", 64'(out_valid), 64'h0);
    chk(occupancy == 4'd0, "mid_rst_occ", 64'(occupancy), 64'h0);
    chk(out_seq == 16'd0, "mid_rst_seq", 64'(out_seq), 64'h0);
    chk(overflow == 1'b0, "mid_rst_overflow", 64'(overflow), 64'h0);
    chk(in_ready == 1'b1, "mid_rst_ready", 64'(in_ready), 64'h1);

    out_ready = 1'b1;
    set_bundle(2'b01, 64'h600, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    wait_drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
